// File: rtl/vga_sync_timer.sv
// vga_sync_timer: pixel/line counters with registered sync, blanking and
// line/frame start decodes for a parameterised raster. Every output is a
// flop; decodes are computed from the next counter values so they line up
// with the hpos/vpos presented in the same cycle.
module vga_sync_timer #(
    parameter int   H_VIS       = 640,  // visible pixels per line
    parameter int   H_FP        = 16,   // horizontal front porch
    parameter int   H_SYNC      = 96,   // hsync width
    parameter int   H_BP        = 48,   // horizontal back porch
    parameter int   V_VIS       = 480,  // visible lines
    parameter int   V_FP        = 10,   // vertical front porch
    parameter int   V_SYNC      = 2,    // vsync width
    parameter int   V_BP        = 33,   // vertical back porch
    parameter logic SYNC_ACTIVE = 1'b0  // level of hsync/vsync during the pulse
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       wrap_h;
    logic       wrap_v;
    logic       hsync_next;
    logic       vsync_next;
    logic       display_next;

    // Next counter values and wrap events, plus decodes of those next values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        h_next = hpos;
        v_next = vpos;
        wrap_h = 1'b0;
        wrap_v = 1'b0;
        if (ce) begin
            if (hpos == H_LAST) begin
                h_next = '0;
                wrap_h = 1'b1;
                if (vpos == V_LAST) begin
                    v_next = '0;
                    wrap_v = 1'b1;
                end else begin
                    v_next = vpos + 10'd1;
                end
            end else begin
                h_next = hpos + 10'd1;
            end
        end
        hsync_next   = ((h_next >= HS_START) && (h_next <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next   = ((v_next >= VS_START) && (v_next <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_next = (h_next < H_VIS_L) && (v_next < V_VIS_L);
    end

    // Register counters, decodes and one-cycle start pulses; reset parks the
    // raster on its last pixel so the first enabled edge starts a new frame.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'hFF;
        end else begin
            // Pulses track the wrap of this edge only, so they drop when ce is low.
            line_start  <= wrap_h;
            frame_start <= wrap_v;
            if (ce) begin
                hpos       <= h_next;
                vpos       <= v_next;
                hsync      <= hsync_next;
                vsync      <= vsync_next;
                display_on <= display_next;
                if (wrap_v) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_timer.sv
// Self-checking bench for vga_sync_timer. The reference model tracks one
// absolute pixel index per instance and derives position, syncs, blanking
// and frame count from it arithmetically. A default-timing instance covers
// line-level behaviour; a small-raster instance with active-high sync makes
// full-frame and 256-frame wrap runs affordable.
module tb_vga_sync_timer;

    localparam int HT_A = 800;
    localparam int VT_A = 525;
    localparam int HT_B = 16;
    localparam int VT_B = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance.
    logic       rst_n_a = 1'b0, ce_a = 1'b0;
    logic       hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a;
    logic [9:0] hpos_a, vpos_a;
    logic [7:0] frame_cnt_a;

    vga_sync_timer u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .ce(ce_a),
        .hsync(hsync_a), .vsync(vsync_a), .display_on(display_on_a),
        .hpos(hpos_a), .vpos(vpos_a),
        .line_start(line_start_a), .frame_start(frame_start_a),
        .frame_cnt(frame_cnt_a)
    );

    // Small-raster instance, 16x12 total, active-high sync.
    logic       rst_n_b = 1'b0, ce_b = 1'b0;
    logic       hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b;
    logic [9:0] hpos_b, vpos_b;
    logic [7:0] frame_cnt_b;

    vga_sync_timer #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE(1'b1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .ce(ce_b),
        .hsync(hsync_b), .vsync(vsync_b), .display_on(display_on_b),
        .hpos(hpos_b), .vpos(vpos_b),
        .line_start(line_start_b), .frame_start(frame_start_b),
        .frame_cnt(frame_cnt_b)
    );

    // Observed output bundles: {hsync,vsync,display_on,hpos,vpos,line_start,frame_start,frame_cnt}.
    logic [32:0] obs_a, obs_b;
    assign obs_a = {hsync_a, vsync_a, display_on_a, hpos_a, vpos_a, line_start_a, frame_start_a, frame_cnt_a};
    assign obs_b = {hsync_b, vsync_b, display_on_b, hpos_b, vpos_b, line_start_b, frame_start_b, frame_cnt_b};

    // Model state: absolute pixel index (-1 = parked by reset) and pulse flags.
    int t_a = -1, t_b = -1;
    bit ls_a, fs_a, ls_b, fs_b;
    logic [32:0] exp_v;

    int checks = 0;
    int errors = 0;

    // Expected output bundle from the raster rules, given the pixel index.
    function automatic logic [32:0] model_vec(int t, bit ls, bit fs,
                                              int hv, int hfp, int hs, int hbp,
                                              int vv, int vfp, int vs, int vbp, bit sa);
        int ht, vt, h, v, f;
        bit hsy, vsy, de;
        ht = hv + hfp + hs + hbp;
        vt = vv + vfp + vs + vbp;
        if (t < 0) begin
            h = ht - 1; v = vt - 1; f = 255;
            hsy = ~sa; vsy = ~sa; de = 1'b0;
        end else begin
            h = t % ht;
            v = (t / ht) % vt;
            f = (t / (ht * vt)) % 256;
            hsy = (h >= hv + hfp && h < hv + hfp + hs) ? sa : ~sa;
            vsy = (v >= vv + vfp && v < vv + vfp + vs) ? sa : ~sa;
            de  = (h < hv) && (v < vv);
        end
        return {hsy, vsy, de, 10'(h), 10'(v), ls, fs, 8'(f)};
    endfunction

    function automatic logic [32:0] exp_a();
        return model_vec(t_a, ls_a, fs_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    function automatic logic [32:0] exp_b();
        return model_vec(t_b, ls_b, fs_b, 8, 2, 3, 3, 6, 2, 2, 2, 1'b1);
    endfunction

    // One clock on instance A with the model advanced alongside; returns #1 after the edge.
    task automatic step_a(input bit ce, input bit rst);
        ce_a = ce; rst_n_a = rst;
        @(posedge clk);
        if (!rst) begin
            t_a = -1; ls_a = 1'b0; fs_a = 1'b0;
        end else if (ce) begin
            t_a++;
            ls_a = (t_a % HT_A) == 0;
            fs_a = (t_a % (HT_A * VT_A)) == 0;
        end else begin
            ls_a = 1'b0; fs_a = 1'b0;
        end
        #1;
    endtask

    task automatic step_b(input bit ce, input bit rst);
        ce_b = ce; rst_n_b = rst;
        @(posedge clk);
        if (!rst) begin
            t_b = -1; ls_b = 1'b0; fs_b = 1'b0;
        end else if (ce) begin
            t_b++;
            ls_b = (t_b % HT_B) == 0;
            fs_b = (t_b % (HT_B * VT_B)) == 0;
        end else begin
            ls_b = 1'b0; fs_b = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step_a(1'($urandom_range(0, 1)), 1'b0);
            exp_v = exp_a();
            checks++;
            if (obs_a !== exp_v) begin
                errors++;
                $display("FAIL reset cyc=%0d got %h exp %h", i, obs_a, exp_v);
            end
        end
    endtask

    task automatic test_first_pixel(input string tag);
        step_a(1'b1, 1'b1);
        exp_v = exp_a();
        checks++;
        if (obs_a !== exp_v) begin
            errors++;
            $display("FAIL %s model got %h exp %h", tag, obs_a, exp_v);
        end
        checks++;
        if ({hpos_a, vpos_a, display_on_a, line_start_a, frame_start_a, frame_cnt_a, hsync_a, vsync_a}
            !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL %s const got h=%0d v=%0d de=%b ls=%b fs=%b fc=%0d hs=%b vs=%b exp 0 0 1 1 1 0 1 1",
                     tag, hpos_a, vpos_a, display_on_a, line_start_a, frame_start_a, frame_cnt_a, hsync_a, vsync_a);
        end
    endtask

    task automatic test_line_sweep();
        for (int i = 0; i < HT_A; i++) begin
            step_a(1'b1, 1'b1);
            exp_v = exp_a();
            checks++;
            if (obs_a !== exp_v) begin
                errors++;
                $display("FAIL line_sweep t=%0d got %h exp %h", t_a, obs_a, exp_v);
            end
        end
    endtask

    // Random ce until the raster passes the (799,10)->(0,11) wrap.
    task automatic test_random_ce();
        int target;
        target = 11 * HT_A + 3;
        for (int i = 0; i < 20000 && t_a < target; i++) begin
            step_a(1'($urandom_range(0, 3) != 0), 1'b1);
            exp_v = exp_a();
            checks++;
            if (obs_a !== exp_v) begin
                errors++;
                $display("FAIL random_ce t=%0d got %h exp %h", t_a, obs_a, exp_v);
            end
        end
        checks++;
        if (t_a < target) begin
            errors++;
            $display("FAIL random_ce_budget reached t=%0d need %0d", t_a, target);
        end
    endtask

    task automatic test_ce_alternate();
        int high_run;
        high_run = 0;
        for (int i = 0; i < 1800; i++) begin
            step_a(1'(i % 2 == 0), 1'b1);
            exp_v = exp_a();
            checks++;
            if (obs_a !== exp_v) begin
                errors++;
                $display("FAIL ce_alternate t=%0d got %h exp %h", t_a, obs_a, exp_v);
            end
            high_run = line_start_a ? high_run + 1 : 0;
            if (high_run > 1) begin
                errors++;
                $display("FAIL ce_alternate_pulse line_start high %0d cycles, exp 1", high_run);
            end
        end
    endtask

    task automatic test_midframe_reset_a();
        step_a(1'b1, 1'b0);
        exp_v = exp_a();
        checks++;
        if (obs_a !== exp_v) begin
            errors++;
            $display("FAIL midframe_reset_a got %h exp %h", obs_a, exp_v);
        end
        test_first_pixel("rerun_first_pixel");
    endtask

    // Small raster: 256+ frames with mostly-on ce, including the frame_cnt wrap.
    task automatic test_frame_wrap_b();
        int ft, target;
        ft = HT_B * VT_B;
        target = 256 * ft + 5;
        for (int i = 0; i < 2; i++) begin
            step_b(1'b1, 1'b0);
            exp_v = exp_b();
            checks++;
            if (obs_b !== exp_v) begin
                errors++;
                $display("FAIL reset_b got %h exp %h", obs_b, exp_v);
            end
        end
        for (int i = 0; i < 70000 && t_b < target; i++) begin
            step_b(1'($urandom_range(0, 7) != 0), 1'b1);
            exp_v = exp_b();
            checks++;
            if (obs_b !== exp_v) begin
                errors++;
                $display("FAIL frame_run_b t=%0d got %h exp %h", t_b, obs_b, exp_v);
            end
            if (fs_b && t_b == 256 * ft) begin
                checks++;
                if (frame_cnt_b !== 8'd0 || frame_start_b !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_cnt_wrap got fc=%0d fs=%b exp 0 1", frame_cnt_b, frame_start_b);
                end
            end
        end
        checks++;
        if (t_b < target) begin
            errors++;
            $display("FAIL frame_run_b_budget reached t=%0d need %0d", t_b, target);
        end
    endtask

    task automatic test_midframe_reset_b();
        int n;
        n = $urandom_range(20, 150);
        for (int i = 0; i < n + 40; i++) begin
            step_b(1'b1, 1'(i != n));
            exp_v = exp_b();
            checks++;
            if (obs_b !== exp_v) begin
                errors++;
                $display("FAIL midframe_reset_b cyc=%0d got %h exp %h", i, obs_b, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel("first_pixel");
        test_line_sweep();
        test_random_ce();
        test_ce_alternate();
        test_midframe_reset_a();
        test_frame_wrap_b();
        test_midframe_reset_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
